// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter.
// Holds the FSM state encoding, the data width and the parity helper.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } state_t;

  // Returns the bit that makes the total parity of data plus this bit even (odd=0) or odd (odd=1).
  function automatic logic parity_bit(input logic [DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while clr is low.
// It raises tick on the terminal count and restarts from zero on the next cycle.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 16,
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  assign tick = !clr && (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a byte FIFO and sends each byte on tx as an async-serial frame.
// Frame format: start bit, 8 data bits sent LSB first, an optional parity bit, then the stop bit(s).
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              byte_done,
  output logic [15:0]       tx_count
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic              par_q;
  logic [2:0]        bit_idx;
  logic [CNT_W-1:0]  baud_cnt;
  logic              baud_clr;
  logic              tick;
  logic              fetch_ok;
  logic              last_stop;

  // The baud counter only runs in the timed states, so it is always zero when START is entered.
  assign baud_clr  = !(state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP});
  assign fetch_ok  = tx_en && !fifo_empty;
  assign last_stop = (bit_idx == LAST_STOP);

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (baud_clr),
    .cnt  (baud_cnt),
    .tick (tick)
  );

  // Outputs are registered: each is loaded on the edge that enters the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      par_q      <= 1'b0;
      bit_idx    <= '0;
      fifo_rd_en <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      byte_done  <= 1'b0;
      tx_count   <= '0;
    end else begin
      fifo_rd_en <= 1'b0;
      byte_done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fetch_ok) begin
            state      <= ST_FETCH;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ST_FETCH: state <= ST_LOAD;
        ST_LOAD: begin
          shreg   <= fifo_data;
          par_q   <= parity_bit(fifo_data, PARITY_ODD);
          bit_idx <= '0;
          tx      <= 1'b0;
          state   <= ST_START;
        end
        ST_START: begin
          if (tick) begin
            tx    <= shreg[0];
            shreg <= shreg >> 1;
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              if (PARITY_EN) begin
                tx    <= par_q;
                state <= ST_PARITY;
              end else begin
                tx    <= 1'b1;
                state <= ST_STOP;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            tx    <= 1'b1;
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          // Decoded one cycle early so the registered pulse lands on the final stop cycle.
          if (last_stop && baud_cnt == PRE_LAST) byte_done <= 1'b1;
          if (tick) begin
            if (last_stop) begin
              tx_count <= tx_count + 16'd1;
              bit_idx  <= '0;
              if (fetch_ok) begin
                state      <= ST_FETCH;
                fifo_rd_en <= 1'b1;
              end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
